// File: rtl/matrix_capture.sv
// HUB75 bus capture: resynchronises the panel bus into clk_in and reports pixels, line latches and OE pulse widths.
// OE pulse-width measurement is compiled in only when MATRIX_CAPTURE_OE_MEASURE_EN is defined.
`timescale 1ns/1ps

module matrix_capture (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       hub_clk,
  input  logic       hub_latch,
  input  logic       hub_oe,
  input  logic [3:0] hub_row,
  input  logic [2:0] hub_rgb_top,
  input  logic [2:0] hub_rgb_bottom,
  output logic       pixel_valid,
  output logic [5:0] pixel_column,
  output logic [2:0] pixel_rgb_top,
  output logic [2:0] pixel_rgb_bottom,
  output logic       line_valid,
  output logic [3:0] line_row,
  output logic [2:0] line_plane,
  output logic [6:0] line_pixels,
  output logic       line_error,
  output logic       oe_valid,
  output logic [9:0] oe_width,
  output logic [3:0] oe_row
);

  typedef struct packed {
    logic       clk;
    logic       latch;
    logic       oe;
    logic [3:0] row;
    logic [2:0] top;
    logic [2:0] bot;
  } hub_t;

  hub_t       meta_q, sync_q;
  logic       clk_hist_q, latch_hist_q;
  logic [1:0] arm_q;
  logic       edge_en, clk_rise, latch_rise, accept;

  logic [5:0] col_q, col_d;
  logic [6:0] cnt_q, cnt_d;
  logic       overrun_q, overrun_d;
  logic       have_prev_q, have_prev_d;
  logic       pix_valid_q, pix_valid_d;
  logic [5:0] pix_col_q, pix_col_d;
  logic [2:0] pix_top_q, pix_top_d, pix_bot_q, pix_bot_d;
  logic       line_valid_q, line_valid_d;
  logic [3:0] line_row_q, line_row_d;
  logic [2:0] line_plane_q, line_plane_d;
  logic [6:0] line_pixels_q, line_pixels_d;
  logic       line_error_q, line_error_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      meta_q       <= '0;
      sync_q       <= '0;
      clk_hist_q   <= 1'b0;
      latch_hist_q <= 1'b0;
      arm_q        <= '0;
    end else begin
      meta_q       <= {hub_clk, hub_latch, hub_oe, hub_row, hub_rgb_top, hub_rgb_bottom};
      sync_q       <= meta_q;
      clk_hist_q   <= sync_q.clk;
      latch_hist_q <= sync_q.latch;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
    end
  end

  // Edges are ignored until the synchronisers have refilled with real pin values after reset.
  assign edge_en    = (arm_q == 2'd3);
  assign clk_rise   = edge_en & sync_q.clk & ~clk_hist_q;
  assign latch_rise = edge_en & sync_q.latch & ~latch_hist_q;
  assign accept     = clk_rise & (cnt_q != 7'd64);

  // NOTE: every variable gets a default first so no path through this block can infer a latch.
  always_comb begin
    col_d         = col_q;
    cnt_d         = cnt_q;
    overrun_d     = overrun_q;
    have_prev_d   = have_prev_q;
    pix_valid_d   = 1'b0;
    pix_col_d     = pix_col_q;
    pix_top_d     = pix_top_q;
    pix_bot_d     = pix_bot_q;
    line_valid_d  = 1'b0;
    line_row_d    = line_row_q;
    line_plane_d  = line_plane_q;
    line_pixels_d = line_pixels_q;
    line_error_d  = line_error_q;

    if (accept) begin
      pix_valid_d = 1'b1;
      pix_col_d   = col_q;
      pix_top_d   = sync_q.top;
      pix_bot_d   = sync_q.bot;
      cnt_d       = cnt_q + 7'd1;
      col_d       = (col_q == 6'd0) ? 6'd0 : col_q - 6'd1;
    end else if (clk_rise) begin
      overrun_d = 1'b1;
    end

    // A pixel arriving with the latch is counted into the line it closes.
    if (latch_rise) begin
      line_valid_d  = 1'b1;
      line_row_d    = sync_q.row;
      line_pixels_d = cnt_d;
      line_error_d  = overrun_d | (cnt_d != 7'd64);
      if (!have_prev_q || (sync_q.row != line_row_q) || (line_plane_q == 3'd0))
        line_plane_d = 3'd5;
      else
        line_plane_d = line_plane_q - 3'd1;
      have_prev_d = 1'b1;
      cnt_d       = '0;
      overrun_d   = 1'b0;
      col_d       = 6'd63;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      col_q         <= 6'd63;
      cnt_q         <= '0;
      overrun_q     <= 1'b0;
      have_prev_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_col_q     <= 6'd63;
      pix_top_q     <= '0;
      pix_bot_q     <= '0;
      line_valid_q  <= 1'b0;
      line_row_q    <= '0;
      line_plane_q  <= 3'd5;
      line_pixels_q <= '0;
      line_error_q  <= 1'b0;
    end else begin
      col_q         <= col_d;
      cnt_q         <= cnt_d;
      overrun_q     <= overrun_d;
      have_prev_q   <= have_prev_d;
      pix_valid_q   <= pix_valid_d;
      pix_col_q     <= pix_col_d;
      pix_top_q     <= pix_top_d;
      pix_bot_q     <= pix_bot_d;
      line_valid_q  <= line_valid_d;
      line_row_q    <= line_row_d;
      line_plane_q  <= line_plane_d;
      line_pixels_q <= line_pixels_d;
      line_error_q  <= line_error_d;
    end
  end

  assign pixel_valid      = pix_valid_q;
  assign pixel_column     = pix_col_q;
  assign pixel_rgb_top    = pix_top_q;
  assign pixel_rgb_bottom = pix_bot_q;
  assign line_valid       = line_valid_q;
  assign line_row         = line_row_q;
  assign line_plane       = line_plane_q;
  assign line_pixels      = line_pixels_q;
  assign line_error       = line_error_q;

`ifdef MATRIX_CAPTURE_OE_MEASURE_EN
  logic       oe_hist_q, oe_rise, oe_fall;
  logic [9:0] oe_cnt_q, oe_width_q;
  logic [3:0] oe_row_start_q, oe_row_q;
  logic       oe_valid_q;

  assign oe_rise = edge_en & sync_q.oe & ~oe_hist_q;
  assign oe_fall = edge_en & ~sync_q.oe & oe_hist_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      oe_hist_q      <= 1'b0;
      oe_cnt_q       <= '0;
      oe_row_start_q <= '0;
      oe_valid_q     <= 1'b0;
      oe_width_q     <= '0;
      oe_row_q       <= '0;
    end else begin
      oe_hist_q  <= sync_q.oe;
      oe_valid_q <= oe_fall;
      if (oe_rise) oe_row_start_q <= sync_q.row;
      if (oe_fall) begin
        oe_width_q <= oe_cnt_q;
        oe_row_q   <= oe_row_start_q;
        oe_cnt_q   <= '0;
      end else if (sync_q.oe && (oe_cnt_q != 10'd1023)) begin
        oe_cnt_q <= oe_cnt_q + 10'd1;
      end
    end
  end

  assign oe_valid = oe_valid_q;
  assign oe_width = oe_width_q;
  assign oe_row   = oe_row_q;
`else
  logic unused_oe;
  assign unused_oe = sync_q.oe;
  assign oe_valid  = 1'b0;
  assign oe_width  = '0;
  assign oe_row    = '0;
`endif

endmodule

// File: tb/tb_matrix_capture.sv
// Scoreboard bench for matrix_capture: stimulus pushes expected pixels/lines/OE pulses, a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_matrix_capture;

`ifdef MATRIX_CAPTURE_OE_MEASURE_EN
  localparam bit OE_EN = 1'b1;
`else
  localparam bit OE_EN = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       hub_clk = 1'b0, hub_latch = 1'b0, hub_oe = 1'b0;
  logic [3:0] hub_row = '0;
  logic [2:0] hub_rgb_top = '0, hub_rgb_bottom = '0;
  logic       pixel_valid, line_valid, line_error, oe_valid;
  logic [5:0] pixel_column;
  logic [2:0] pixel_rgb_top, pixel_rgb_bottom, line_plane;
  logic [3:0] line_row, oe_row;
  logic [6:0] line_pixels;
  logic [9:0] oe_width;

  matrix_capture dut (
    .clk_in(clk_in), .reset(reset), .hub_clk(hub_clk), .hub_latch(hub_latch), .hub_oe(hub_oe),
    .hub_row(hub_row), .hub_rgb_top(hub_rgb_top), .hub_rgb_bottom(hub_rgb_bottom),
    .pixel_valid(pixel_valid), .pixel_column(pixel_column), .pixel_rgb_top(pixel_rgb_top),
    .pixel_rgb_bottom(pixel_rgb_bottom), .line_valid(line_valid), .line_row(line_row),
    .line_plane(line_plane), .line_pixels(line_pixels), .line_error(line_error),
    .oe_valid(oe_valid), .oe_width(oe_width), .oe_row(oe_row)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed { logic [5:0] col; logic [2:0] top; logic [2:0] bot; } pix_exp_t;
  typedef struct packed { logic [3:0] row; logic [2:0] plane; logic [6:0] pixels; logic error; } line_exp_t;
  typedef struct packed { logic [9:0] width; logic [3:0] row; } oe_exp_t;

  pix_exp_t  pix_q[$];
  line_exp_t line_q[$];
  oe_exp_t   oe_q[$];

  int n_vec = 0, n_fail = 0, oe_seen = 0;

  // Reference model: pin-level edges seen since the last latch, and the previous line's row/plane.
  int         line_n = 0;
  bit         have_prev = 1'b0;
  logic [3:0] prev_row = '0;
  logic [2:0] prev_plane = 3'd5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_near(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
    n_vec++;
    if ((act + tol < exp) || (act > exp + tol)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  function automatic void model_pixel(input logic [2:0] top, input logic [2:0] bot);
    pix_exp_t e;
    if (line_n < 64) begin
      e.col = 6'(63 - line_n);
      e.top = top;
      e.bot = bot;
      pix_q.push_back(e);
    end
    line_n++;
  endfunction

  function automatic void model_latch(input logic [3:0] row);
    line_exp_t e;
    e.row    = row;
    e.pixels = 7'((line_n > 64) ? 64 : line_n);
    e.error  = (line_n != 64);
    e.plane  = (!have_prev || row != prev_row || prev_plane == 3'd0) ? 3'd5 : 3'(prev_plane - 3'd1);
    line_q.push_back(e);
    have_prev  = 1'b1;
    prev_row   = row;
    prev_plane = e.plane;
    line_n     = 0;
  endfunction

  task automatic pulse(input logic [2:0] top, input logic [2:0] bot);
    @(negedge clk_in);
    hub_rgb_top = top;
    hub_rgb_bottom = bot;
    repeat (2) @(negedge clk_in);
    hub_clk = 1'b1;
    model_pixel(top, bot);
    repeat (2) @(negedge clk_in);
    hub_clk = 1'b0;
  endtask

  task automatic do_latch(input logic [3:0] row);
    @(negedge clk_in);
    hub_row = row;
    repeat (2) @(negedge clk_in);
    hub_latch = 1'b1;
    model_latch(row);
    repeat (2) @(negedge clk_in);
    hub_latch = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic rand_line(input int n, input logic [3:0] row);
    for (int i = 0; i < n; i++) pulse(3'($urandom_range(7)), 3'($urandom_range(7)));
    do_latch(row);
  endtask

  task automatic check_reset_state();
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_pixel_column", pixel_column, 63);
    check("rst_pixel_rgb_top", pixel_rgb_top, 0);
    check("rst_pixel_rgb_bottom", pixel_rgb_bottom, 0);
    check("rst_line_valid", line_valid, 0);
    check("rst_line_row", line_row, 0);
    check("rst_line_plane", line_plane, 5);
    check("rst_line_pixels", line_pixels, 0);
    check("rst_line_error", line_error, 0);
    check("rst_oe_valid", oe_valid, 0);
    check("rst_oe_width", oe_width, 0);
    check("rst_oe_row", oe_row, 0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    pix_exp_t  pe;
    line_exp_t le;
    oe_exp_t   oe;
    if (pixel_valid) begin
      if (pix_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL pixel_unexpected: got pixel column %0d, expected no pixel (t=%0t)", pixel_column, $time);
      end else begin
        pe = pix_q.pop_front();
        check("pixel_column", pixel_column, pe.col);
        check("pixel_rgb_top", pixel_rgb_top, pe.top);
        check("pixel_rgb_bottom", pixel_rgb_bottom, pe.bot);
      end
    end
    if (line_valid) begin
      if (line_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL line_unexpected: got line row %0d, expected no line (t=%0t)", line_row, $time);
      end else begin
        le = line_q.pop_front();
        check("line_row", line_row, le.row);
        check("line_plane", line_plane, le.plane);
        check("line_pixels", line_pixels, le.pixels);
        check("line_error", line_error, le.error);
      end
    end
    if (oe_valid) begin
      oe_seen++;
      if (oe_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL oe_unexpected: got oe width %0d, expected no oe strobe (t=%0t)", oe_width, $time);
      end else begin
        oe = oe_q.pop_front();
        check_near("oe_width", oe_width, oe.width, 1);
        check("oe_row", oe_row, oe.row);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] c;
    oe_exp_t    oe_e;

    repeat (4) @(negedge clk_in);
    check_reset_state();
    reset = 1'b1;
    repeat (5) @(negedge clk_in);

    // Full line with top data equal to the low column bits.
    for (int i = 0; i < 64; i++) begin
      c = 6'(63 - i);
      pulse(c[2:0], 3'($urandom_range(7)));
    end
    do_latch(4'd3);

    // Plane countdown on a repeated row, then a row change.
    for (int l = 0; l < 6; l++) rand_line(64, 4'd5);
    rand_line(64, 4'd6);

    // Overrun, recovery, short line, empty line.
    rand_line(70, 4'd6);
    rand_line(64, 4'd6);
    rand_line(40, 4'd8);
    rand_line(65, 4'd8);
    do_latch(4'd8);

    // 64th pixel arrives on the same cycle as the latch.
    for (int i = 0; i < 63; i++) pulse(3'($urandom_range(7)), 3'($urandom_range(7)));
    @(negedge clk_in);
    hub_rgb_top = 3'd5;
    hub_rgb_bottom = 3'd2;
    hub_row = 4'd4;
    repeat (2) @(negedge clk_in);
    hub_clk = 1'b1;
    hub_latch = 1'b1;
    model_pixel(3'd5, 3'd2);
    model_latch(4'd4);
    repeat (2) @(negedge clk_in);
    hub_clk = 1'b0;
    hub_latch = 1'b0;
    repeat (2) @(negedge clk_in);

    for (int l = 0; l < 4; l++) rand_line($urandom_range(70), 4'($urandom_range(2, 1)));

    // OE pulse of 200 cycles; row changes mid-pulse and must not be reported.
    @(negedge clk_in);
    hub_row = 4'd9;
    repeat (3) @(negedge clk_in);
    oe_seen = 0;
    hub_oe = 1'b1;
    if (OE_EN) begin
      oe_e.width = 10'd200;
      oe_e.row = 4'd9;
      oe_q.push_back(oe_e);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (i == 4) hub_row = 4'd2;
    end
    hub_oe = 1'b0;
    repeat (8) @(negedge clk_in);
    check("oe_strobe_count", oe_seen, OE_EN ? 1 : 0);

    // Reset in the middle of a line, with pin activity during reset and hub_clk high at release.
    for (int i = 0; i < 30; i++) pulse(3'($urandom_range(7)), 3'($urandom_range(7)));
    repeat (5) @(negedge clk_in);
    hub_clk = 1'b1;
    reset = 1'b0;
    line_n = 0;
    have_prev = 1'b0;
    repeat (3) @(negedge clk_in);
    check_reset_state();
    for (int i = 0; i < 5; i++) begin
      hub_clk = 1'b0;
      hub_latch = (i == 2);
      repeat (2) @(negedge clk_in);
      hub_clk = 1'b1;
      repeat (2) @(negedge clk_in);
    end
    hub_latch = 1'b0;
    check("rst_line_valid_held", line_valid, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk_in);
    hub_clk = 1'b0;
    rand_line(64, 4'd7);

    repeat (10) @(negedge clk_in);
    check("pix_queue_left", pix_q.size(), 0);
    check("line_queue_left", line_q.size(), 0);
    check("oe_queue_left", oe_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_capture.md
MATRIX_CAPTURE -- requirements
Module: matrix_capture

Interface
REQ-001 SHALL have port: clk_in  input  1  system clock; all logic on rising edge; at least 4x the HUB75 pixel clock rate.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: hub_clk  input  1  HUB75 pixel clock, asynchronous to clk_in.
REQ-004 SHALL have port: hub_latch  input  1  HUB75 row latch, active-high.
REQ-005 SHALL have port: hub_oe  input  1  HUB75 output enable, active-high (LEDs lit).
REQ-006 SHALL have port: hub_row  input  4  HUB75 row address.
REQ-007 SHALL have port: hub_rgb_top / hub_rgb_bottom  input  3 each  upper/lower half-panel sub-pixel data.
REQ-008 SHALL have port: pixel_valid  output  1  one-cycle strobe per captured pixel.
REQ-009 SHALL have port: pixel_column  output  6  column of the captured pixel.
REQ-010 SHALL have port: pixel_rgb_top / pixel_rgb_bottom  output  3 each  captured data.
REQ-011 SHALL have port: line_valid  output  1  one-cycle strobe per latch.
REQ-012 SHALL have port: line_row  output  4; line_plane  output  3; line_pixels  output  7; line_error  output  1.
REQ-013 SHALL have port: oe_valid  output  1; oe_width  output  10; oe_row  output  4.

Function
REQ-014 SHALL pass hub_clk, hub_latch, hub_oe, hub_row and both rgb buses through identical 2-flop synchronisers, plus one history flop for edge detection.
REQ-015 SHALL detect a hub_clk rising edge when the synchronised value is 1 and the history value is 0; latency from pin edge to pixel_valid is 3 clk_in cycles.
REQ-016 SHALL register rgb data on the same cycle as the detected hub_clk edge, so data and clock stay aligned.
REQ-017 SHALL keep column counter col: loaded with 63 on reset and on each latch; it decrements on each accepted pixel.
REQ-018 SHALL, per accepted pixel, assert pixel_valid for one cycle with pixel_column=col and registered rgb.
REQ-019 SHALL keep pixel count cnt (7 bits), cleared on latch; it saturates at 64.
REQ-020 SHALL, on a 65th or later hub_clk edge before a latch, emit no pixel_valid, leave col at 0 and set an internal overrun flag.
REQ-021 SHALL, on a hub_latch rising edge, for one cycle assert line_valid with: line_row = synchronised hub_row; line_pixels = cnt; line_error = overrun OR (cnt != 64).
REQ-022 SHALL, on the same cycle as REQ-021, clear cnt and overrun and reload col to 63.
REQ-023 SHALL keep plane counter: line_plane = 5 if line_row differs from previous latch's row or previous plane was 0; otherwise previous plane minus 1.
REQ-024 SHALL, if hub_clk and hub_latch edges are detected in the same cycle, accept the pixel first, then close the line with that pixel counted.
REQ-025 SHALL count clk_in cycles while synchronised hub_oe is high, saturating at 1023.
REQ-026 SHALL, on hub_oe falling edge, for one cycle assert oe_valid with oe_width = count and oe_row = synchronised hub_row sampled at the oe rising edge; count clears.
REQ-027 SHALL hold all data outputs stable between strobes.

Reset
REQ-028 SHALL, while reset is low: all strobes=0, pixel_column=63, line_plane=5, all other outputs, counters, flags and synchronisers=0.
REQ-029 SHALL, when reset is asserted mid-line, discard the partial line and emit no strobes; it resumes cleanly at the next latch.
REQ-030 SHALL suppress edge detection for the first 3 cycles after reset release.

Configuration
REQ-031 SHALL compile OE measurement (REQ-025/026) only when MATRIX_CAPTURE_OE_MEASURE_EN is defined.
REQ-032 SHALL, when MATRIX_CAPTURE_OE_MEASURE_EN is undefined, tie oe_valid, oe_width and oe_row to 0 and remove the counter logic; all other behaviour is unchanged.

Verification
REQ-033 SHALL cover: 64 hub_clk pulses, rgb_top=col[2:0], then latch, row=3 -> 64 pixel_valid, columns 63..0 with matching data; line_valid row=3 pixels=64 error=0.
REQ-034 SHALL cover: 6 consecutive full lines on row 5, then a line on row 6 -> line_plane 5,4,3,2,1,0 then 5.
REQ-035 SHALL cover: 70 hub_clk pulses then latch -> 64 pixel_valid, line_pixels=64, line_error=1; the next 64-pixel line has error=0.
REQ-036 SHALL cover: 40 pulses then latch -> line_pixels=40, line_error=1, last pixel_column=24.
REQ-037 SHALL cover: hub_oe high for 200 clk_in cycles with row=9 -> oe_valid, oe_width=200 (+/-1), oe_row=9; with macro undefined, oe_valid never asserts.
REQ-038 SHALL cover: reset low after 30 pixels, release, then 64 pixels and latch -> no strobes during reset; next line_pixels=64, error=0, plane=5.
